// File: rtl/mc_cu_pkg.sv
// Shared encodings and state type for the multi-cycle RV32I control unit.
// MC_CU_BRANCH_EXT_EN enables bne/blt/bge/bltu/bgeu on top of beq.
package mc_cu_pkg;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXEC_R,
      S_EXEC_I, S_ALUWB, S_BRANCH, S_JAL, S_JALR1, S_JALR2, S_LUI
   } mc_state_t;

   localparam logic [2:0] ALU_ADD  = 3'b000;
   localparam logic [2:0] ALU_SUB  = 3'b001;
   localparam logic [2:0] ALU_AND  = 3'b010;
   localparam logic [2:0] ALU_OR   = 3'b011;
   localparam logic [2:0] ALU_XOR  = 3'b100;
   localparam logic [2:0] ALU_SLT  = 3'b101;
   localparam logic [2:0] ALU_SLTU = 3'b110;

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_J = 3'b011;
   localparam logic [2:0] IMM_U = 3'b100;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_DATA   = 2'b01;
   localparam logic [1:0] RES_ALURES = 2'b10;
   localparam logic [1:0] RES_IMM    = 2'b11;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_REG   = 2'b10;
   localparam logic [1:0] SRCB_REG   = 2'b00;
   localparam logic [1:0] SRCB_IMM   = 2'b01;
   localparam logic [1:0] SRCB_FOUR  = 2'b10;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   function automatic logic br_supported(input logic [2:0] f3);
`ifdef MC_CU_BRANCH_EXT_EN
      return (f3 != 3'b010) && (f3 != 3'b011);
`else
      return f3 == 3'b000;
`endif
   endfunction

   // Compare ops leave a nonzero ALU result when "less than" holds, so
   // inverted-sense branches (bne/blt/bltu) take on !zero.
   function automatic logic br_taken(input logic [2:0] f3, input logic z);
`ifdef MC_CU_BRANCH_EXT_EN
      return z ^ (f3[2] ^ f3[0]);
`else
      return z & (f3 == 3'b000);
`endif
   endfunction

endpackage

// File: rtl/mc_cu_alu_dec.sv
// ALUControl decode from func3/func7[5]; shift encodings are flagged unsupported.
module mc_alu_dec
   import mc_cu_pkg::*;
(
   input  logic [2:0] func3,
   input  logic       func7_5,
   input  logic       is_rtype,
   output logic [2:0] alu_control,
   output logic       shift
);

   always_comb begin
      alu_control = ALU_ADD;
      shift       = 1'b0;
      case (func3)
         3'b000:  alu_control = (is_rtype && func7_5) ? ALU_SUB : ALU_ADD;
         3'b111:  alu_control = ALU_AND;
         3'b110:  alu_control = ALU_OR;
         3'b100:  alu_control = ALU_XOR;
         3'b010:  alu_control = ALU_SLT;
         3'b011:  alu_control = ALU_SLTU;
         default: shift = 1'b1;
      endcase
   end

endmodule

// File: rtl/mc_cu.sv
// Moore FSM sequencing a shared-ALU, shared-memory RV32I datapath.
// Branch coverage depends on MC_CU_BRANCH_EXT_EN (see mc_cu_pkg).
module mc_cu
   import mc_cu_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] opcode,
   input  logic [2:0] func3,
   input  logic [6:0] func7,
   input  logic       zero,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [2:0] ALUControl,
   output logic [2:0] ImmSrc,
   output logic       instr_done,
   output logic       illegal
);

   mc_state_t  state, state_next;
   logic       pc_wr, mem_wr, ir_wr, reg_wr, done, ill;
   logic [2:0] dec_func3, dec_alu;
   logic       dec_f7, dec_rtype, dec_shift;
   logic       unused_func7;

   assign unused_func7 = ^{func7[6], func7[4:0]};

   // Branches reuse the decoder: eq/ne map to sub, lt/ge to slt, ltu/geu to sltu.
   always_comb begin
      dec_func3 = func3;
      dec_f7    = func7[5];
      dec_rtype = (state == S_EXEC_R);
      if (state == S_BRANCH) begin
         dec_func3 = func3[2] ? {2'b01, func3[1]} : 3'b000;
         dec_f7    = 1'b1;
         dec_rtype = 1'b1;
      end
   end

   mc_alu_dec u_alu_dec (
      .func3       (dec_func3),
      .func7_5     (dec_f7),
      .is_rtype    (dec_rtype),
      .alu_control (dec_alu),
      .shift       (dec_shift)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= S_FETCH;
      else     state <= state_next;
   end

   always_comb begin
      state_next = S_FETCH;
      pc_wr      = 1'b0;
      mem_wr     = 1'b0;
      ir_wr      = 1'b0;
      reg_wr     = 1'b0;
      done       = 1'b0;
      ill        = 1'b0;
      AdrSrc     = 1'b0;
      ResultSrc  = RES_ALUOUT;
      ALUSrcA    = SRCA_PC;
      ALUSrcB    = SRCB_REG;
      ALUControl = ALU_ADD;
      ImmSrc     = IMM_I;
      case (state)
         S_FETCH: begin
            ir_wr      = 1'b1;
            pc_wr      = 1'b1;
            ALUSrcB    = SRCB_FOUR;
            ResultSrc  = RES_ALURES;
            state_next = S_DECODE;
         end
         S_DECODE: begin
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_IMM;
            if (opcode == OP_BRANCH)   ImmSrc = IMM_B;
            else if (opcode == OP_JAL) ImmSrc = IMM_J;
            case (opcode)
               OP_LOAD, OP_STORE: state_next = S_MEMADR;
               OP_RTYPE:          state_next = S_EXEC_R;
               OP_ITYPE:          state_next = S_EXEC_I;
               OP_JAL:            state_next = S_JAL;
               OP_JALR:           state_next = S_JALR1;
               OP_LUI:            state_next = S_LUI;
               OP_BRANCH: begin
                  if (br_supported(func3)) state_next = S_BRANCH;
                  else                     ill = 1'b1;
               end
               default:           ill = 1'b1;
            endcase
         end
         S_MEMADR: begin
            ALUSrcA    = SRCA_REG;
            ALUSrcB    = SRCB_IMM;
            ImmSrc     = (opcode == OP_STORE) ? IMM_S : IMM_I;
            state_next = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            AdrSrc     = 1'b1;
            state_next = S_MEMWB;
         end
         S_MEMWB: begin
            ResultSrc = RES_DATA;
            reg_wr    = 1'b1;
            done      = 1'b1;
         end
         S_MEMWRITE: begin
            AdrSrc = 1'b1;
            mem_wr = 1'b1;
            done   = 1'b1;
         end
         S_EXEC_R, S_EXEC_I: begin
            ALUSrcA    = SRCA_REG;
            ALUSrcB    = (state == S_EXEC_I) ? SRCB_IMM : SRCB_REG;
            ALUControl = dec_alu;
            if (dec_shift) ill = 1'b1;
            else           state_next = S_ALUWB;
         end
         S_ALUWB: begin
            reg_wr = 1'b1;
            done   = 1'b1;
         end
         S_BRANCH: begin
            ALUSrcA    = SRCA_REG;
            ALUControl = dec_alu;
            done       = 1'b1;
            pc_wr      = br_taken(func3, zero);
         end
         // PC <- ALUOut (target), ALUOut <- OldPC + 4 for the link write
         S_JAL, S_JALR2: begin
            ALUSrcA    = SRCA_OLDPC;
            ALUSrcB    = SRCB_FOUR;
            pc_wr      = 1'b1;
            state_next = S_ALUWB;
         end
         S_JALR1: begin
            ALUSrcA    = SRCA_REG;
            ALUSrcB    = SRCB_IMM;
            state_next = S_JALR2;
         end
         S_LUI: begin
            ImmSrc    = IMM_U;
            ResultSrc = RES_IMM;
            reg_wr    = 1'b1;
            done      = 1'b1;
         end
         default: state_next = S_FETCH;
      endcase
   end

   assign PCWrite    = pc_wr  & ~rst;
   assign MemWrite   = mem_wr & ~rst;
   assign IRWrite    = ir_wr  & ~rst;
   assign RegWrite   = reg_wr & ~rst;
   assign instr_done = done   & ~rst;
   assign illegal    = ill    & ~rst;

endmodule
